// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through circular buffer for complex multiplier results.
// Optional RESULT_FIFO_STATS_EN adds a saturating pop counter on result_count.
module result_fifo #(
  parameter int RES_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sw_rst,
  input  logic                 res_val,
  output logic                 res_ready,
  input  logic [RES_WIDTH-1:0] res_re,
  input  logic [RES_WIDTH-1:0] res_im,
  output logic                 out_val,
  input  logic                 out_ready,
  output logic [RES_WIDTH-1:0] out_re,
  output logic [RES_WIDTH-1:0] out_im,
  output logic [CNT_WIDTH-1:0] level,
  output logic                 full,
  output logic                 empty
`ifdef RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]          result_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [2*RES_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_level;
  logic                   w_push;
  logic                   w_pop;
  assign full      = r_level == CNT_WIDTH'(DEPTH);
  assign empty     = r_level == '0;
  assign res_ready = ~full;
  assign out_val   = ~empty;
  assign level     = r_level;
  assign w_push    = res_val && res_ready;
  assign w_pop     = out_val && out_ready;
  assign {out_re, out_im} = r_mem[r_rd_ptr];
  // Storage is not reset; out_re/out_im are only meaningful while out_val=1.
  always_ff @(posedge clk)
    if (w_push && !sw_rst) r_mem[r_wr_ptr] <= {res_re, res_im};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (sw_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) r_level <= r_level + CNT_WIDTH'(1);
      else if (w_pop && !w_push) r_level <= r_level - CNT_WIDTH'(1);
    end
  end
`ifdef RESULT_FIFO_STATS_EN
  logic [15:0] r_result_count;
  assign result_count = r_result_count;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_result_count <= '0;
    else if (sw_rst) r_result_count <= '0;
    else if (w_pop && r_result_count != 16'hFFFF) r_result_count <= r_result_count + 16'd1;
  end
`endif
endmodule
